// File: rtl/arith_pkg.sv
// Shared arithmetic-lab definitions: divider state encodings and sizing helpers.
package arith_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned CNT_W     = $clog2(2 * DEF_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    // Bit-counter width for a divider of the given divisor width.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(2 * w);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   p,
    input  logic             din,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   p_next,
    output logic             qbit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           unused_msb;

    // P is always below the divisor between steps, so its MSB never carries data.
    assign unused_msb = p[WIDTH];

    assign shifted = {p[WIDTH-1:0], din};
    assign trial   = shifted - {1'b0, divisor};
    assign qbit    = ~trial[WIDTH];
    assign p_next  = qbit ? trial : shifted;

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per clock.
module seq_divider
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero
);

    localparam int unsigned CW    = cnt_width(WIDTH);
    localparam int unsigned LAST  = 2 * WIDTH - 1;

    div_state_t           state;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   dvd_sr;
    logic [WIDTH-1:0]     dvs;
    logic [WIDTH:0]       p;
    logic [2*WIDTH-1:0]   q_sr;

    logic [WIDTH:0]       p_next;
    logic                 qbit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .p       (p),
        .din     (dvd_sr[2*WIDTH-1]),
        .divisor (dvs),
        .p_next  (p_next),
        .qbit    (qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            dvd_sr      <= '0;
            dvs         <= '0;
            p           <= '0;
            q_sr        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        dvd_sr      <= dividend;
                        dvs         <= divisor;
                        p           <= '0;
                        q_sr        <= '0;
                        cnt         <= '0;
                        quotient    <= '0;
                        remainder   <= '0;
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            // Zero divisor completes immediately with a saturated quotient.
                            quotient    <= '1;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= ST_RUN;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    p      <= p_next;
                    dvd_sr <= {dvd_sr[2*WIDTH-2:0], 1'b0};
                    q_sr   <= {q_sr[2*WIDTH-2:0], qbit};
                    if (cnt == CW'(LAST)) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= {q_sr[2*WIDTH-2:0], qbit};
                        remainder <= p_next[WIDTH-1:0];
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider with hand-computed results.
module tb_seq_divider;

    localparam int unsigned WIDTH = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [2*WIDTH-1:0] dividend;
    logic [WIDTH-1:0]   divisor;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] quotient;
    logic [WIDTH-1:0]   remainder;
    logic               div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive a request at a falling edge; the following rising edge accepts it.
    task automatic issue(input logic [7:0] dvd, input logic [3:0] dvs);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
    endtask

    // Starting in the cycle after acceptance, count busy cycles until done, then check results.
    task automatic wait_done(input string tag, input int exp_busy, input logic [7:0] eq,
                             input logic [3:0] er, input logic ez);
        int nb = 0;
        int n  = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) nb++;
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 32'(n >= 40), 32'd0);
        chk({tag, "_busycnt"}, 32'(nb), 32'(exp_busy));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, "_q"}, 32'(quotient), 32'(eq));
        chk({tag, "_r"}, 32'(remainder), 32'(er));
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);

        // Reset wins over a simultaneous start.
        start = 1'b1; dividend = 8'd200; divisor = 4'd13;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        chk("rst_no_start", 32'(busy | done), 32'd0);

        issue(8'd200, 4'd13);
        chk("t1_q_cleared_in_run", 32'(quotient), 32'd0);
        wait_done("t1", 8, 8'd15, 4'd5, 1'b0);
        @(negedge clk);
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_q_held", 32'(quotient), 32'd15);
        chk("t1_r_held", 32'(remainder), 32'd5);

        issue(8'd225, 4'd15); wait_done("t2a", 8, 8'd15, 4'd0, 1'b0);
        issue(8'd255, 4'd1);  wait_done("t2b", 8, 8'd255, 4'd0, 1'b0);
        issue(8'd12, 4'd15);  wait_done("t3a", 8, 8'd0, 4'd12, 1'b0);
        issue(8'd0, 4'd9);    wait_done("t3b", 8, 8'd0, 4'd0, 1'b0);

        // Divide by zero: done immediately in the cycle after acceptance.
        issue(8'd77, 4'd0);
        chk("t4_done_next", 32'(done), 32'd1);
        wait_done("t4", 0, 8'd255, 4'd0, 1'b1);
        @(negedge clk);
        chk("t4_done_pulse", 32'(done), 32'd0);
        chk("t4_dbz_held", 32'(div_by_zero), 32'd1);

        // Restart attempt during busy cycle 3 is ignored.
        issue(8'd100, 4'd7);
        repeat (2) @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 4'd13;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5", 5, 8'd14, 4'd2, 1'b0);
        @(negedge clk);
        chk("t5_no_second_run", 32'(busy | done), 32'd0);

        // Reset during busy cycle 4 aborts without a done pulse.
        issue(8'd200, 4'd13);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_q", 32'(quotient), 32'd0);
        chk("t6_r", 32'(remainder), 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 10; i++) begin
                if (done === 1'b1 || busy === 1'b1) seen++;
                @(negedge clk);
            end
            chk("t6_quiet_after_abort", 32'(seen), 32'd0);
        end
        issue(8'd50, 4'd6); wait_done("t6b", 8, 8'd8, 4'd2, 1'b0);

        // Start presented in the DONE cycle is accepted back-to-back.
        start = 1'b1; dividend = 8'd100; divisor = 4'd7;
        @(negedge clk);
        start = 1'b0;
        chk("t7_busy_b2b", 32'(busy), 32'd1);
        chk("t7_q_cleared", 32'(quotient), 32'd0);
        wait_done("t7", 8, 8'd14, 4'd2, 1'b0);

        // Back-to-back into divide by zero from the DONE cycle.
        start = 1'b1; dividend = 8'd9; divisor = 4'd0;
        @(negedge clk);
        start = 1'b0;
        chk("t8_dbz_done", 32'(done), 32'd1);
        wait_done("t8", 0, 8'd255, 4'd0, 1'b1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
